// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit the bus, request-to-send, shift one byte
// (plus odd parity and stop) out on device clock falls, then check the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int CW = $clog2(INHIBIT_CYCLES + REQ_CYCLES + TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE} state_t;
  state_t state, state_nx;

  // Line index 0 is the PS/2 clock, index 1 the PS/2 data.
  logic [1:0]         sync1, sync2, filt;
  logic [1:0][FW-1:0] fcnt;
  logic               fall;

  logic [CW-1:0] cnt;
  logic [3:0]    k;
  logic [9:0]    frame;
  logic          data_drv;
  logic          in_link, timeout;

  // fall is high in the single cycle where the filtered clock has just dropped.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      filt  <= 2'b11;
      fcnt  <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= {ps2_data_in, ps2_clk_in};
      sync2 <= sync1;
      fall  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
          if (i == 0 && !sync2[i]) fall <= 1'b1;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign in_link = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout = in_link && (cnt == TO_LAST);

  always_comb begin
    state_nx    = state;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = data_drv;
    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nx = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == INH_LAST) state_nx = REQ;
      end
      REQ: begin
        ps2_clk_oe = 1'b1;
        if (cnt == REQ_LAST) state_nx = SHIFT;
      end
      SHIFT: begin
        if (timeout) state_nx = DONE;
        else if (fall && k == 4'd9) state_nx = ACK;
      end
      ACK: begin
        if (timeout) state_nx = DONE;
        else if (fall) state_nx = filt[1] ? DONE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (timeout || filt == 2'b11) state_nx = DONE;
      end
      DONE: begin
        tx_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = ~tx_ready;

  // The timeout counter runs on from clock release through ACK and WAIT_IDLE.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      frame    <= '0;
      data_drv <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == IDLE || (state_nx != state && !in_link)) cnt <= '0;
      else cnt <= cnt + CW'(1);

      unique case (state)
        IDLE: if (tx_valid) begin
          frame    <= {1'b1, ~^tx_data, tx_data};
          err_code <= 2'b00;
          k        <= '0;
        end
        INHIBIT: if (state_nx == REQ) data_drv <= 1'b1;
        SHIFT: if (!timeout && fall) begin
          k        <= k + 4'd1;
          data_drv <= ~frame[0];
          frame    <= {1'b0, frame[9:1]};
        end
        default: ;
      endcase

      if (timeout) err_code <= 2'b01;
      else if (state == ACK && fall && filt[1]) err_code <= 2'b10;
      if (state_nx == DONE || state_nx == IDLE) data_drv <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain bus.
module tb_ps2_host_tx;
  logic       clk = 1'b0, clrn = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done, ps2_clk_oe, ps2_data_oe;
  logic [1:0] err_code;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
  wire        ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
  wire        ps2_data_in = ~(ps2_data_oe | dev_data_low);

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, oe_cycles = 0;
  logic [1:0] done_err = 2'b00;
  logic ready_after = 1'b0, prev_done = 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .REQ_CYCLES(4), .TIMEOUT_CYCLES(5000), .FILTER_LEN(2)) dut (
    .clk(clk), .clrn(clrn), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .err_code(err_code),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (ps2_clk_oe) oe_cycles <= oe_cycles + 1;
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_err <= err_code;
    end
    if (prev_done) ready_after <= tx_ready;
    prev_done <= tx_done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Returns at the first negedge where the host has released the clock.
  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = ps2_clk_oe; end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = !ps2_clk_oe; end
    end
  endtask

  // Device: 11 clock pulses, 40 high then 40 low; data sampled at the end of each high phase.
  task automatic dev_run(input bit ack, output logic [10:0] fr);
    bit ok;
    fr = '0;
    wait_release(ok);
    chk("release", 32'(ok), 32'd1);
    if (!ok) return;
    for (int i = 0; i < 11; i++) begin
      repeat (40) @(negedge clk);
      fr[i] = ps2_data_in;
      if (i == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (20) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int i = 0; i < 200 && done_cnt == base; i++) @(posedge clk);
    chk(tag, 32'(done_cnt - base), 32'd1);
  endtask

  initial begin
    logic [10:0] fr;
    int base, oe_base, n;
    bit ok;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED: parity 1, device ACKs
    base = done_cnt; oe_base = oe_cycles;
    send(8'hED);
    chk("busy_inhibit", 32'(busy), 32'd1);
    dev_run(1'b1, fr);
    wait_done(base, "ed_done");
    repeat (3) @(negedge clk);
    chk("ed_frame", 32'(fr), 32'h7DA);
    chk("ed_err", 32'(done_err), 32'd0);
    chk("ed_clk_oe_cycles", 32'(oe_cycles - oe_base), 32'd24);
    chk("ed_ready_after", 32'(ready_after), 32'd1);
    chk("ed_single_done", 32'(done_cnt - base), 32'd1);

    // Back-to-back 0x01 (parity 0) then 0xFF (parity 1)
    base = done_cnt;
    send(8'h01);
    dev_run(1'b1, fr);
    wait_done(base, "b01_done");
    chk("b01_frame", 32'(fr), 32'h402);
    chk("b01_err", 32'(done_err), 32'd0);
    base = done_cnt;
    send(8'hFF);
    dev_run(1'b1, fr);
    wait_done(base, "bff_done");
    chk("bff_frame", 32'(fr), 32'h7FE);
    chk("bff_err", 32'(done_err), 32'd0);

    // Silent device: timeout exactly 5000 cycles after clock release
    send(8'h42);
    wait_release(ok);
    chk("to_release", 32'(ok), 32'd1);
    n = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      n++;
      if (tx_done) break;
    end
    chk("to_latency", 32'(n), 32'd5000);
    chk("to_err", 32'(err_code), 32'd1);
    chk("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    @(negedge clk);
    chk("to_ready_after", 32'(tx_ready), 32'd1);

    // No ACK: data left high on the 11th edge
    base = done_cnt;
    send(8'h3C);
    dev_run(1'b0, fr);
    wait_done(base, "nak_done");
    chk("nak_frame", 32'(fr), 32'h678);
    chk("nak_err", 32'(done_err), 32'd2);
    repeat (10) @(negedge clk);

    // Request during SHIFT is dropped; a 1-cycle clock glitch is filtered out
    base = done_cnt;
    send(8'hAA);
    fork
      dev_run(1'b1, fr);
      begin
        bit ok5;
        wait_release(ok5);
        repeat (340) @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (80) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_done(base, "aa_done");
    oe_base = oe_cycles;
    chk("aa_frame", 32'(fr), 32'h754);
    chk("aa_err", 32'(done_err), 32'd0);
    repeat (100) @(negedge clk);
    chk("aa_single_done", 32'(done_cnt - base), 32'd1);
    chk("aa_not_queued", 32'(oe_cycles - oe_base), 32'd0);
    chk("aa_idle", 32'(tx_ready), 32'd1);

    // Reset at k=5 of 0x0F, then 0xF4 completes normally
    base = done_cnt;
    send(8'h0F);
    wait_release(ok);
    chk("rs_release", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i < 4) begin
        repeat (40) @(negedge clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    chk("rs_k5_data_oe", 32'(ps2_data_oe), 32'd1);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    chk("rs_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("rs_ready", 32'(tx_ready), 32'd1);
    chk("rs_err", 32'(err_code), 32'd0);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    chk("rs_no_done", 32'(done_cnt - base), 32'd0);
    base = done_cnt;
    send(8'hF4);
    dev_run(1'b1, fr);
    wait_done(base, "f4_done");
    chk("f4_frame", 32'(fr), 32'h5E8);
    chk("f4_err", 32'(done_err), 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
